// File: rtl/read_ctrl_sync.sv
// Read-side pointer/flag controller for a dual-clock FIFO: synchronises the Gray write pointer,
// advances the read pointer, and derives registered empty/almost-empty/level flags in clk_r.
module read_ctrl_sync #(
    parameter int depth       = 8,
    parameter int adr_width   = $clog2(depth),
    parameter int sync_stages = 2,
    parameter int ae_thresh   = 1
) (
    input  logic                 clk_r,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic [adr_width:0]   wr_ptr_gray,
    output logic                 read,
    output logic [adr_width-1:0] read_adr,
    output logic [adr_width:0]   rd_ptr_gray,
    output logic                 FIFO_empty,
    output logic                 almost_empty,
    output logic [adr_width:0]   rd_level,
    output logic                 rd_valid,
    output logic                 underflow
);

    localparam int PW = adr_width + 1;
    localparam logic [PW-1:0] AE_THR = PW'(ae_thresh);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [sync_stages-1:0][PW-1:0] r_sync;
    logic [PW-1:0] r_rd_bin;
    logic [PW-1:0] r_rd_gray;
    logic          r_empty;
    logic          r_aempty;
    logic [PW-1:0] r_level;
    logic          r_valid;
    logic          r_underflow;

    logic [PW-1:0] w_wq_sync;
    logic [PW-1:0] w_wq_bin;
    logic          w_read;
    logic [PW-1:0] w_rd_bin_nxt;
    logic [PW-1:0] w_rd_gray_nxt;
    logic [PW-1:0] w_level_nxt;

    assign w_wq_sync     = r_sync[sync_stages-1];
    assign w_wq_bin      = gray2bin(w_wq_sync);
    assign w_read        = rd_en & ~r_empty;
    assign w_rd_bin_nxt  = r_rd_bin + PW'(w_read);
    assign w_rd_gray_nxt = w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
    // Level uses the lagging synchronised write pointer, so flags can only be pessimistic.
    assign w_level_nxt   = w_wq_bin - w_rd_bin_nxt;

    always_ff @(posedge clk_r or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= wr_ptr_gray;
            for (int i = 1; i < sync_stages; i++)
                r_sync[i] <= r_sync[i-1];
        end
    end

    always_ff @(posedge clk_r or posedge reset) begin
        if (reset) begin
            r_rd_bin    <= '0;
            r_rd_gray   <= '0;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_level     <= '0;
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_bin    <= w_rd_bin_nxt;
            r_rd_gray   <= w_rd_gray_nxt;
            r_empty     <= (w_rd_gray_nxt == w_wq_sync);
            r_aempty    <= (w_level_nxt <= AE_THR);
            r_level     <= w_level_nxt;
            r_valid     <= w_read;
            r_underflow <= rd_en & r_empty;
        end
    end

    assign read         = w_read;
    assign read_adr     = r_rd_bin[adr_width-1:0];
    assign rd_ptr_gray  = r_rd_gray;
    assign FIFO_empty   = r_empty;
    assign almost_empty = r_aempty;
    assign rd_level     = r_level;
    assign rd_valid     = r_valid;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_read_ctrl_sync.sv
// Directed bench for read_ctrl_sync (depth 8, two sync stages, ae_thresh 1).
module tb_read_ctrl_sync;

    logic       clk_r = 1'b0;
    logic       reset;
    logic       rd_en;
    logic [3:0] wr_ptr_gray;
    logic       read;
    logic [2:0] read_adr;
    logic [3:0] rd_ptr_gray;
    logic       FIFO_empty;
    logic       almost_empty;
    logic [3:0] rd_level;
    logic       rd_valid;
    logic       underflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] wr_bin;
    logic [3:0] rd_m;
    logic [3:0] prev_g;

    read_ctrl_sync dut (
        .clk_r        (clk_r),
        .reset        (reset),
        .rd_en        (rd_en),
        .wr_ptr_gray  (wr_ptr_gray),
        .read         (read),
        .read_adr     (read_adr),
        .rd_ptr_gray  (rd_ptr_gray),
        .FIFO_empty   (FIFO_empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .rd_valid     (rd_valid),
        .underflow    (underflow)
    );

    always #5 clk_r = ~clk_r;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_r);
        #1;
    endtask

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rd_en = 1'b0;
        wr_ptr_gray = 4'd0;
        repeat (3) tick();
        chk("rst_empty", 32'(FIFO_empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_level", 32'(rd_level), 0);
        chk("rst_read", 32'(read), 0);
        chk("rst_gray", 32'(rd_ptr_gray), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_uflow", 32'(underflow), 0);
        reset = 1'b0;
        tick();

        // write pointer 0 -> 1: empty falls on the third edge
        wr_ptr_gray = 4'b0001;
        tick();
        chk("t2_e1_empty", 32'(FIFO_empty), 1);
        tick();
        chk("t2_e2_empty", 32'(FIFO_empty), 1);
        tick();
        chk("t2_e3_empty", 32'(FIFO_empty), 0);
        chk("t2_level", 32'(rd_level), 1);
        chk("t2_ae", 32'(almost_empty), 1);
        rd_en = 1'b1;
        #1;
        chk("t2_read", 32'(read), 1);
        chk("t2_adr", 32'(read_adr), 0);
        tick();
        chk("t2_empty_after", 32'(FIFO_empty), 1);
        chk("t2_valid", 32'(rd_valid), 1);
        chk("t2_level0", 32'(rd_level), 0);
        chk("t2_gray", 32'(rd_ptr_gray), 1);
        chk("t2_no_read", 32'(read), 0);

        // underflow: rd_en held while empty
        tick();
        chk("t4_uflow1", 32'(underflow), 1);
        chk("t4_gray1", 32'(rd_ptr_gray), 1);
        chk("t4_read1", 32'(read), 0);
        tick();
        chk("t4_uflow2", 32'(underflow), 1);
        chk("t4_valid", 32'(rd_valid), 0);
        chk("t4_gray2", 32'(rd_ptr_gray), 1);
        rd_en = 1'b0;
        tick();
        chk("t4_uflow_off", 32'(underflow), 0);

        // asynchronous reset mid-run, away from the clock edge
        #3;
        reset = 1'b1;
        wr_ptr_gray = 4'd0;
        #1;
        chk("t1_empty", 32'(FIFO_empty), 1);
        chk("t1_ae", 32'(almost_empty), 1);
        chk("t1_level", 32'(rd_level), 0);
        chk("t1_adr", 32'(read_adr), 0);
        chk("t1_gray", 32'(rd_ptr_gray), 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // drain five entries
        wr_ptr_gray = 4'b0111;
        tick();
        tick();
        chk("t3_e2_empty", 32'(FIFO_empty), 1);
        tick();
        chk("t3_empty", 32'(FIFO_empty), 0);
        chk("t3_level5", 32'(rd_level), 5);
        chk("t3_ae5", 32'(almost_empty), 0);
        rd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_read", 32'(read), 1);
            chk("t3_adr", 32'(read_adr), k);
            tick();
            chk("t3_level", 32'(rd_level), 4 - k);
            chk("t3_valid", 32'(rd_valid), 1);
            chk("t3_ae", 32'(almost_empty), ((4 - k) <= 1) ? 1 : 0);
            chk("t3_empty_k", 32'(FIFO_empty), (k == 4) ? 1 : 0);
        end
        chk("t3_gray5", 32'(rd_ptr_gray), 7);
        #1;
        chk("t3_stop", 32'(read), 0);
        tick();
        chk("t3_valid_off", 32'(rd_valid), 0);
        chk("t3_uflow", 32'(underflow), 1);
        rd_en = 1'b0;
        tick();

        // wrap: 20 passes of 8 writes/reads
        wr_bin = 4'd5;
        rd_m   = 4'd5;
        for (int p = 0; p < 20; p++) begin
            int t;
            wr_bin = wr_bin + 4'd8;
            wr_ptr_gray = g(wr_bin);
            t = 0;
            while (FIFO_empty && t < 10) begin
                tick();
                t++;
            end
            chk("t5_fill", 32'(FIFO_empty), 0);
            rd_en = 1'b1;
            for (int j = 0; j < 8; j++) begin
                #1;
                prev_g = rd_ptr_gray;
                chk("t5_read", 32'(read), 1);
                chk("t5_adr", 32'(read_adr), 32'(rd_m[2:0]));
                tick();
                rd_m = rd_m + 4'd1;
                chk("t5_gray", 32'(rd_ptr_gray), 32'(g(rd_m)));
                chk("t5_onebit", $countones(rd_ptr_gray ^ prev_g), 1);
                if (rd_m == 4'd0) begin
                    chk("t5_wrap_from", 32'(prev_g), 8);
                    chk("t5_wrap_to", 32'(rd_ptr_gray), 0);
                end
            end
            rd_en = 1'b0;
            chk("t5_empty", 32'(FIFO_empty), 1);
        end

        // full, then steady concurrent read+write
        wr_bin = wr_bin + 4'd8;
        wr_ptr_gray = g(wr_bin);
        repeat (3) tick();
        chk("t6_level8", 32'(rd_level), 8);
        chk("t6_ae", 32'(almost_empty), 0);
        chk("t6_empty", 32'(FIFO_empty), 0);
        for (int c = 1; c <= 6; c++) begin
            rd_en = 1'b1;
            wr_bin = wr_bin + 4'd1;
            wr_ptr_gray = g(wr_bin);
            tick();
            if (c >= 2)
                chk("t6_steady", 32'(rd_level), 6);
        end
        rd_en = 1'b0;
        repeat (4) tick();
        chk("t6_settle", 32'(rd_level), 8);
        chk("t6_ae_end", 32'(almost_empty), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
